// File: rtl/seg_scan_pkg.sv
// seg_scan_display shared types and constants: mode enum, hex-to-segment
// table, idle drive levels and a leading-digit helper.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    LED    = 2'd0,
    CYCLE  = 2'd1,
    BRANCH = 2'd2,
    JMP    = 2'd3
  } mode_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // gfedcba, active-low; entry n is the pattern for hex digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index of the most significant nonzero nibble; 0 when the value is 0
  function automatic logic [2:0] msd_index(input logic [31:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i*4 +: 4] != 4'h0) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Bundle between the CPU-side sources / button and the display scanner.
interface seg_scan_if;
  logic [31:0] Leddata;
  logic [31:0] Count_cycle;
  logic [31:0] Count_branch;
  logic [31:0] Count_jmp;
  logic        btn_mode;
  logic        freeze;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic [1:0]  mode;

  modport master (
    output Leddata, Count_cycle, Count_branch, Count_jmp, btn_mode, freeze,
    input  seg, an, mode
  );

  modport slave (
    input  Leddata, Count_cycle, Count_branch, Count_jmp, btn_mode, freeze,
    output seg, an, mode
  );
endinterface

// File: rtl/seg_scan_display_btn_debounce.sv
// Button debouncer: 2-FF synchroniser plus a stability counter; output is
// the accepted (stable) level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then accept a new level after it has differed long enough
  always_ff @(posedge clk) begin
    if (!clr) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 8-digit hex display of one of four CPU values, with a
// debounced mode button and per-frame snapshotting.
// Optional build macro SEG_BLANK_LEADING_ZERO_EN blanks leading zero digits.
module seg_scan_display
  import seg_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input logic      clk,
  input logic      clr,
  seg_scan_if.slave bus
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [2:0]       idx;
  logic [31:0]      snap;
  logic [7:0]       an_r;
  logic [7:0]       seg_r;
  logic             stable;
  logic             stable_q;
  mode_e            state;
  mode_e            state_nxt;

  logic        tick;
  logic        frame_end;
  logic        rise;
  logic [31:0] src;
  logic [6:0]  pat;
  logic        dp;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .clr  (clr),
    .btn  (bus.btn_mode),
    .level(stable)
  );

  // Scan timing, press edge and selected source
  always_comb begin
    tick      = (div == DIV_LAST);
    frame_end = tick && (idx == 3'd7);
    rise      = stable && !stable_q;
    case (state)
      LED:     src = bus.Leddata;
      CYCLE:   src = bus.Count_cycle;
      BRANCH:  src = bus.Count_branch;
      default: src = bus.Count_jmp;
    endcase
  end

  // Segment pattern and decimal point for the digit currently scanned
  always_comb begin
    pat = HEX_SEG[snap[{idx, 2'b00} +: 4]];
`ifdef SEG_BLANK_LEADING_ZERO_EN
    if (idx > msd_index(snap)) pat = SEG_BLANK;
`else
    pat = HEX_SEG[snap[{idx, 2'b00} +: 4]];
`endif
    dp = (idx != {1'b0, state});
  end

  // Mode state register
  always_ff @(posedge clk) begin
    if (!clr) state <= LED;
    else      state <= state_nxt;
  end

  // Mode next-state: advance once per accepted press
  always_comb begin
    state_nxt = state;
    if (rise) begin
      case (state)
        LED:     state_nxt = CYCLE;
        CYCLE:   state_nxt = BRANCH;
        BRANCH:  state_nxt = JMP;
        default: state_nxt = LED;
      endcase
    end
  end

  // Divider, digit index, frame snapshot and registered display drive
  always_ff @(posedge clk) begin
    if (!clr) begin
      div      <= '0;
      idx      <= 3'd0;
      snap     <= 32'd0;
      an_r     <= AN_OFF;
      seg_r    <= SEG_OFF;
      stable_q <= 1'b0;
    end else begin
      div      <= tick ? '0 : div + DIV_W'(1);
      stable_q <= stable;
      if (tick) idx <= idx + 3'd1;
      if (frame_end && !bus.freeze) snap <= src;
      an_r  <= ~(8'b1 << idx);
      seg_r <= {dp, pat};
    end
  end

  assign bus.an   = an_r;
  assign bus.seg  = seg_r;
  assign bus.mode = state;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display (CLK_DIV=4, DEBOUNCE_CYCLES=3). Honours
// SEG_BLANK_LEADING_ZERO_EN when the build defines it.
module tb_seg_scan_display;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DEB     = 3;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  seg_scan_if bus ();

  seg_scan_display #(
    .CLK_DIV        (CLK_DIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_mode = 0;

  logic [6:0] hex_tb [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Expected {dp, gfedcba} for digit d of value v with mode m
  function automatic logic [7:0] exp_seg(input logic [31:0] v, input int d, input int m);
    logic [6:0] p;
    int top;
    top = 0;
    for (int i = 0; i < 8; i++) if (v[i*4 +: 4] != 4'h0) top = i;
    p = hex_tb[v[d*4 +: 4]];
`ifdef SEG_BLANK_LEADING_ZERO_EN
    if (d > top) p = 7'h7F;
`endif
    return {(d == m) ? 1'b0 : 1'b1, p};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check 32 consecutive samples (8 digits x CLK_DIV) starting at the current one
  task automatic check_digits(input logic [31:0] v, input int m,
                              input int chg_digit, input logic [31:0] chg_val);
    logic [7:0] e_an;
    for (int d = 0; d < 8; d++) begin
      for (int s = 0; s < int'(CLK_DIV); s++) begin
        if (!(d == 0 && s == 0)) @(negedge clk);
        if (d == chg_digit && s == 1) bus.Leddata = chg_val;
        e_an = 8'hFF;
        e_an[d] = 1'b0;
        chk("an", 32'(bus.an), 32'(e_an));
        chk("seg", 32'(bus.seg), 32'(exp_seg(v, d, m)));
      end
      chk("mode", 32'(bus.mode), 32'(m));
    end
  endtask

  task automatic wait_frame_start();
    logic [7:0] prev;
    prev = bus.an;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (prev == 8'h7F && bus.an == 8'hFE) return;
      prev = bus.an;
    end
    chk("frame_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_frame(input bit do_chk, input logic [31:0] v, input int m,
                             input int chg_digit, input logic [31:0] chg_val);
    wait_frame_start();
    if (do_chk) check_digits(v, m, chg_digit, chg_val);
    else repeat (8 * CLK_DIV - 1) @(negedge clk);
  endtask

  task automatic press(input int hold);
    bus.btn_mode = 1'b1;
    repeat (hold) @(negedge clk);
    bus.btn_mode = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  // Reset for one edge from the current point, then check the restarted first frame
  task automatic do_reset();
    clr = 1'b0;
    @(negedge clk);
    chk("rst_an", 32'(bus.an), 32'h0000_00FF);
    chk("rst_seg", 32'(bus.seg), 32'h0000_00FF);
    chk("rst_mode", 32'(bus.mode), 32'd0);
    clr = 1'b1;
    exp_mode = 0;
    @(negedge clk);
    check_digits(32'd0, 0, -1, 32'd0);
  endtask

  logic [31:0] val;
  logic [31:0] nval;

  initial begin
    clr              = 1'b0;
    bus.Leddata      = 32'h1234_ABCD;
    bus.Count_cycle  = 32'd0;
    bus.Count_branch = 32'd0;
    bus.Count_jmp    = 32'd0;
    bus.btn_mode     = 1'b0;
    bus.freeze       = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_an", 32'(bus.an), 32'h0000_00FF);
    chk("init_seg", 32'(bus.seg), 32'h0000_00FF);
    chk("init_mode", 32'(bus.mode), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    check_digits(32'd0, 0, -1, 32'd0);
    check_frame(1, 32'h1234_ABCD, 0, -1, 32'd0);

    // Leading-zero cases and random LED values
    bus.Leddata = 32'h0000_00A5;
    check_frame(0, 0, 0, -1, 0);
    check_frame(1, 32'h0000_00A5, 0, -1, 0);
    bus.Leddata = 32'd0;
    check_frame(0, 0, 0, -1, 0);
    check_frame(1, 32'd0, 0, -1, 0);
    for (int r = 0; r < 3; r++) begin
      val = $urandom;
      if (r == 0) val = val >> ($urandom_range(1, 7) * 4);
      bus.Leddata = val;
      check_frame(0, 0, 0, -1, 0);
      check_frame(1, val, 0, -1, 0);
    end

    // Button: a one-cycle glitch is rejected, a held press advances once
    bus.btn_mode = 1'b1;
    @(negedge clk);
    bus.btn_mode = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_mode", 32'(bus.mode), 32'd0);
    press(6);
    exp_mode = 1;
    chk("press1_mode", 32'(bus.mode), 32'(exp_mode));
    repeat (20) @(negedge clk);
    chk("release_mode", 32'(bus.mode), 32'(exp_mode));

    // Walk through BRANCH and JMP with random values, wrap back to LED
    for (int p = 0; p < 3; p++) begin
      press(int'($urandom_range(6, 12)));
      exp_mode = (exp_mode + 1) % 4;
      chk("press_mode", 32'(bus.mode), 32'(exp_mode));
      if (exp_mode == 2) begin
        val = $urandom;
        bus.Count_branch = val;
        check_frame(0, 0, 0, -1, 0);
        check_frame(1, val, exp_mode, -1, 0);
      end else if (exp_mode == 3) begin
        val = $urandom;
        bus.Count_jmp = val;
        check_frame(0, 0, 0, -1, 0);
        check_frame(1, val, exp_mode, -1, 0);
      end
    end
    chk("wrap_mode", 32'(bus.mode), 32'd0);

    // Freeze holds the snapshot on CYCLE
    press(8);
    exp_mode = 1;
    bus.Count_cycle = 32'h0000_0010;
    check_frame(0, 0, 0, -1, 0);
    check_frame(1, 32'h0000_0010, 1, -1, 0);
    bus.freeze      = 1'b1;
    bus.Count_cycle = 32'hFFFF_FFFF;
    check_frame(1, 32'h0000_0010, 1, -1, 0);
    check_frame(1, 32'h0000_0010, 1, -1, 0);
    bus.freeze = 1'b0;
    check_frame(1, 32'h0000_0010, 1, -1, 0);
    check_frame(1, 32'hFFFF_FFFF, 1, -1, 0);

    // Back to LED; a mid-frame change waits for the next boundary
    for (int p = 0; p < 3; p++) press(7);
    exp_mode = 0;
    chk("back_led_mode", 32'(bus.mode), 32'd0);
    val = $urandom;
    nval = ~val;
    bus.Leddata = val;
    check_frame(0, 0, 0, -1, 0);
    check_frame(1, val, 0, int'($urandom_range(0, 6)), nval);
    check_frame(1, nval, 0, -1, 0);

    // Reset mid-frame after leaving LED mode
    press(6);
    wait_frame_start();
    repeat ($urandom_range(1, 20)) @(negedge clk);
    do_reset();
    check_frame(1, nval, 0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
